// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART physical layer.
// Holds the baud divisor helper, data width and the FSM state type.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Rounded clock-to-baud ratio.
    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable bit-period counter with full-bit and half-bit ticks.
// Ports: clk, rst_n, i_clr (hold at 0), o_tick (last count), o_half (mid-bit).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick,
    output logic o_half
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);
    assign o_half = (r_cnt == HALF);

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART serializer and deserializer with independent TX and RX FSMs.
// Ports: clk, rst_n, tx_start/tx_data/tx/tx_busy, rx/data_out/rx_busy/done.
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_busy,
    output logic       done
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    // ---------------- TX ----------------
    uart_state_e          r_tx_state;
    uart_state_e          w_tx_state_nxt;
    logic [3:0]           r_tx_bit;
    logic [3:0]           w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_tx_busy;
    logic                 w_tx_clr;
    logic                 w_tx_tick;
    logic                 w_tx_half_unused;

    assign w_tx_clr = (r_tx_state == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tx_clr),
        .o_tick(w_tx_tick),
        .o_half(w_tx_half_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_bit   <= '0;
            r_tx_data  <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= (w_tx_state_nxt != ST_IDLE);
            if (r_tx_state == ST_IDLE && tx_start) begin
                r_tx_data <= tx_data;
            end
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_bit_nxt   = r_tx_bit;
        unique case (r_tx_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_tx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = ST_DATA;
                    w_tx_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_tx_tick) begin
                    if (r_tx_bit == LAST_BIT) begin
                        w_tx_state_nxt = ST_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Line level is registered from the next state so tx never glitches.
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_tx_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = r_tx_data[w_tx_bit_nxt[2:0]];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;

    // ---------------- RX ----------------
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    uart_state_e          r_rx_state;
    uart_state_e          w_rx_state_nxt;
    logic [3:0]           r_rx_bit;
    logic [3:0]           w_rx_bit_nxt;
    logic                 r_rx_err;
    logic                 w_rx_err_nxt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_rx_busy;
    logic                 r_done;
    logic                 w_rx_clr;
    logic                 w_rx_tick;
    logic                 w_rx_half;
    logic                 w_rx_shift_en;
    logic                 w_rx_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_rx_clr),
        .o_tick(w_rx_tick),
        .o_half(w_rx_half)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_bit   <= '0;
            r_rx_err   <= 1'b0;
            r_rx_shift <= '0;
            r_data_out <= '0;
            r_rx_busy  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_err   <= w_rx_err_nxt;
            r_rx_busy  <= (w_rx_state_nxt != ST_IDLE);
            r_done     <= w_rx_good;
            if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
            if (w_rx_good) begin
                r_data_out <= r_rx_shift;
            end
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_err_nxt   = r_rx_err;
        unique case (r_rx_state)
            ST_IDLE: begin
                w_rx_err_nxt = 1'b0;
                if (!r_rx_sync) begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_rx_half) begin
                    if (!r_rx_sync) begin
                        w_rx_state_nxt = ST_DATA;
                        w_rx_bit_nxt   = '0;
                    end else begin
                        w_rx_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_tick) begin
                    if (r_rx_bit == LAST_BIT) begin
                        w_rx_state_nxt = ST_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                // After a low stop sample, hold until the line recovers.
                if (r_rx_err) begin
                    if (r_rx_sync) begin
                        w_rx_state_nxt = ST_IDLE;
                        w_rx_err_nxt   = 1'b0;
                    end
                end else if (w_rx_tick) begin
                    if (r_rx_sync) begin
                        w_rx_state_nxt = ST_IDLE;
                    end else begin
                        w_rx_err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // The counter restarts at mid start bit so later ticks land mid-bit.
    always_comb begin
        w_rx_clr      = 1'b0;
        w_rx_shift_en = 1'b0;
        w_rx_good     = 1'b0;
        unique case (r_rx_state)
            ST_IDLE:  w_rx_clr = 1'b1;
            ST_START: w_rx_clr = w_rx_half;
            ST_DATA:  w_rx_shift_en = w_rx_tick;
            ST_STOP:  w_rx_good = !r_rx_err && w_rx_tick && r_rx_sync;
        endcase
    end

    assign data_out = r_data_out;
    assign rx_busy  = r_rx_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_phy.sv
// Directed self-checking bench for uart_phy with 16 clocks per bit.
// Covers reset, TX framing, handshake, busy-ignore, loopback and RX errors.
module tb_uart_phy;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_busy;
    logic       done;
    logic       loop;
    logic       rx_drv;

    int checks = 0;
    int errors = 0;

    logic [8:0] txd_q[$];
    logic [7:0] rx_q[$];
    int         done_busy_cnt = 0;
    int         done_wide_cnt = 0;
    logic       done_prev = 1'b0;

    always #5 clk = ~clk;

    assign rx = loop ? tx : rx_drv;

    uart_phy #(
        .CLK_FREQ    (160_000),
        .BAUD        (10_000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
        .data_out(data_out),
        .rx_busy (rx_busy),
        .done    (done)
    );

    // Independent wire decoder: {frame_ok, byte} per frame seen on tx.
    initial begin : tx_decoder
        logic [7:0] b;
        logic       ok;
        b = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === 1'b1);
                txd_q.push_back({ok, b});
            end
        end
    end

    // Records done pulses with their width and rx_busy overlap.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            rx_q.push_back(data_out);
            if (rx_busy !== 1'b0) done_busy_cnt++;
            if (done_prev) done_wide_cnt++;
        end
        done_prev = (done === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL send_wait: tx_busy stuck, byte %h", b);
        end
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        tx_start = 1'b0;
        tx_data  = 8'h00;
        loop     = 1'b0;
        rx_drv   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_busy: got %b want 0", tx_busy);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_busy: got %b want 0", rx_busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", data_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_single();
        logic [159:0] cap;
        logic [159:0] bcap;
        logic [159:0] exp;
        logic [9:0]   frame;
        frame = {1'b1, 8'h53, 1'b0};
        for (int i = 0; i < 160; i++) exp[i] = frame[i / CPB];
        @(negedge clk);
        tx_data  = 8'h53;
        tx_start = 1'b1;
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_busy_pre: got %b want 0", tx_busy);
        end
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            tx_start = 1'b0;
            cap[i]   = tx;
            bcap[i]  = tx_busy;
        end
        checks++;
        if (cap !== exp) begin
            errors++;
            $display("FAIL tx_wave: got %h want %h", cap, exp);
        end
        checks++;
        if (bcap !== {160{1'b1}}) begin
            errors++;
            $display("FAIL tx_busy_len: got %h want all ones", bcap);
        end
        @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_end: busy %b tx %b want 0 1", tx_busy, tx);
        end
    endtask

    task automatic test_handshake();
        logic [7:0] msg [7];
        int n;
        msg = '{8'h53, 8'h3A, 8'h32, 8'h35, 8'h34, 8'h35, 8'h2F};
        txd_q.delete();
        for (int i = 0; i < 7; i++) send_byte(msg[i]);
        n = 0;
        while (tx_busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (txd_q.size() != 7) begin
            errors++;
            $display("FAIL hs_count: got %0d want 7", txd_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < txd_q.size()) begin
                checks++;
                if (txd_q[i] !== {1'b1, msg[i]}) begin
                    errors++;
                    $display("FAIL hs_byte%0d: got %h want %h",
                             i, txd_q[i], {1'b1, msg[i]});
                end
            end
        end
    endtask

    task automatic test_tx_ignore();
        int n;
        txd_q.delete();
        send_byte(8'h41);
        n = 0;
        while (tx_busy === 1'b1 && n < 400) begin
            if (n >= 30 && n < 60) begin
                tx_start = (n % 2 == 0);
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        checks++;
        if (n != 160) begin
            errors++;
            $display("FAIL ign_busy_len: got %0d want 160", n);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_restart: busy %b want 0", tx_busy);
        end
        checks++;
        if (txd_q.size() != 1) begin
            errors++;
            $display("FAIL ign_count: got %0d want 1", txd_q.size());
        end else begin
            checks++;
            if (txd_q[0] !== 9'h141) begin
                errors++;
                $display("FAIL ign_byte: got %h want 141", txd_q[0]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] msg [5];
        int n;
        msg = '{8'h4C, 8'h31, 8'h3A, 8'h30, 8'h0A};
        loop = 1'b1;
        rx_q.delete();
        done_busy_cnt = 0;
        done_wide_cnt = 0;
        for (int i = 0; i < 5; i++) send_byte(msg[i]);
        n = 0;
        while (rx_q.size() < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rx_q.size() != 5) begin
            errors++;
            $display("FAIL lb_count: got %0d want 5", rx_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== msg[i]) begin
                    errors++;
                    $display("FAIL lb_byte%0d: got %h want %h",
                             i, rx_q[i], msg[i]);
                end
            end
        end
        checks++;
        if (done_wide_cnt != 0) begin
            errors++;
            $display("FAIL lb_done_width: got %0d want 0", done_wide_cnt);
        end
        checks++;
        if (done_busy_cnt != 0) begin
            errors++;
            $display("FAIL lb_done_busy: got %0d want 0", done_busy_cnt);
        end
        loop = 1'b0;
    endtask

    task automatic test_rx_errors();
        int   n0;
        logic seen_busy;
        rx_drv    = 1'b1;
        n0        = rx_q.size();
        seen_busy = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx_drv = 1'b1;
            @(negedge clk);
            if (rx_busy === 1'b1) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: got %b want 1", seen_busy);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got %b want 0", rx_busy);
        end
        checks++;
        if (rx_q.size() != n0) begin
            errors++;
            $display("FAIL glitch_done: got %0d want %0d", rx_q.size(), n0);
        end
        drive_frame(8'h44, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (rx_q.size() != n0) begin
            errors++;
            $display("FAIL ferr_done: got %0d want %0d", rx_q.size(), n0);
        end
        checks++;
        if (data_out !== 8'h0A) begin
            errors++;
            $display("FAIL ferr_data: got %h want 0a", data_out);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_busy: got %b want 0", rx_busy);
        end
        drive_frame(8'h42, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (rx_q.size() != n0 + 1) begin
            errors++;
            $display("FAIL good_done: got %0d want %0d",
                     rx_q.size(), n0 + 1);
        end
        checks++;
        if (data_out !== 8'h42) begin
            errors++;
            $display("FAIL good_data: got %h want 42", data_out);
        end
    endtask

    task automatic test_reset_mid();
        loop = 1'b1;
        send_byte(8'h55);
        repeat (60) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b1 || rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: tx %b rx %b want 1 1",
                     tx_busy, rx_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_tx: tx %b busy %b want 1 0",
                     tx, tx_busy);
        end
        checks++;
        if (rx_busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_rx: busy %b done %b want 0 0",
                     rx_busy, done);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst_data: got %h want 00", data_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        loop  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_handshake();
        test_tx_ignore();
        test_loopback();
        test_rx_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
